bincnt_seq: RTL



---
 rtl/bincnt_seq_if.sv | 45 ++++
 rtl/bincnt_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bincnt_seq_if.sv
// rtl/bincnt_seq_if.sv - word-in / count-out handshake bundle for bincnt_seq
//
// Purpose : groups the input word handshake and the result handshake of
//           bincnt_seq into one port.
// Signals : in_valid, in_ready, in_data[W-1:0]       - word from producer
//           out_valid, out_ready, out_cnt[CW-1:0]    - Hamming weight to consumer
//           out_par                                  - parity, only with BINCNT_SEQ_PARITY_EN
// Modports: master - producer/consumer side; slave - bincnt_seq side.
// Macro   : BINCNT_SEQ_PARITY_EN adds out_par.

interface bincnt_seq_if #(
    parameter int W = 32
);
    localparam int CW = $clog2(W + 1);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cnt;
`ifdef BINCNT_SEQ_PARITY_EN
    logic          out_par;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_cnt, out_par
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_cnt, out_par
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_cnt
    );
`endif
endinterface

// File: rtl/bincnt_seq.sv
// rtl/bincnt_seq.sv - sequential population counter over 7-bit chunks
//
// Purpose : counts the ones in a W-bit word using one shared 7-input counter,
//           one chunk per cycle, and returns the total over valid/ready.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           clr   - synchronous abort back to IDLE, discards any result
//           bus   - bincnt_seq_if.slave (in_valid/in_ready/in_data,
//                   out_valid/out_ready/out_cnt[, out_par])
// Macro   : BINCNT_SEQ_PARITY_EN adds out_par = out_cnt[0].
// Modules : counter7b3 - combinational 7-input, 3-bit-output counter
//           bincnt_seq - top

module counter7b3 (
    input  logic [6:0] d,
    output logic [2:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 7; i++) begin
            cnt = cnt + {2'b00, d[i]};
        end
    end
endmodule

module bincnt_seq #(
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    bincnt_seq_if.slave bus
);
    localparam int CHUNKS = (W + 6) / 7;
    localparam int CW     = $clog2(W + 1);
    localparam int SW     = CHUNKS * 7;
    // idx needs at least one bit even when a single chunk covers the word
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] acc;
    logic [IW-1:0] idx;
    logic [SW-1:0] shift;
    logic [2:0]    part;
    logic          accept;
    logic          last;

    // The upper SW-W bits of the load are zero so padding never adds to acc
    counter7b3 u_cnt (
        .d   (shift[6:0]),
        .cnt (part)
    );

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (idx == IW'(CHUNKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_cnt   = '0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_cnt   = acc;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over any handshake on the same edge
        if (clr) begin
            state_next = IDLE;
        end
    end

`ifdef BINCNT_SEQ_PARITY_EN
    // Bit 0 of the registered count is the XOR of the word
    assign bus.out_par = (state == DONE) && acc[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            idx   <= '0;
            shift <= '0;
        end else if (clr) begin
            acc   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift <= SW'(bus.in_data);
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc + CW'(part);
                    shift <= shift >> 7;
                    idx   <= idx + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule
